fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
//   IF-stage producer for the fetch/decode pipeline register.
//   - Generates the PC and issues instruction-memory requests, one outstanding at a time.
//   - Drives instr / PCf / PCPlus4F, which the F/D register samples every clk.
//   - Honours hazard-unit stall (StallF) and execute-stage redirect (PCSrcE / PCTargetE).
//   - Inserts NOP bubbles whenever no valid instruction is available.
//
// PARAMETERS
//   DATA_WIDTH  32            PC / instruction width
//   RESET_PC    32'h0000_0000 first fetch address after reset
//
// PORTS
//   clk            in   1           clock, rising edge
//   rst_n          in   1           synchronous reset, active-low
//   StallF         in   1           hold current F outputs, no new consumption
//   PCSrcE         in   1           redirect request (taken branch / jump)
//   PCTargetE      in   DATA_WIDTH  redirect target
//   imem_req       out  1           request valid
//   imem_addr      out  DATA_WIDTH  request address (word aligned)
//   imem_ready     in   1           request accepted when imem_req & imem_ready
//   imem_rsp_valid in   1           response data valid
//   imem_rsp_data  in   DATA_WIDTH  fetched instruction
//   instr          out  DATA_WIDTH  instruction to F/D register
//   PCf            out  DATA_WIDTH  PC of instr
//   PCPlus4F       out  DATA_WIDTH  PCf + 4
//   fetch_valid    out  1           instr is a real fetch (0 = bubble)
//
// BEHAVIOUR
//   Reset (rst_n=0 at posedge)
//   - pc_q=RESET_PC; state=S_IDLE; kill=0; imem_req=0.
//   - Outputs: instr=NOP (32'h0000_0013), PCf=0, PCPlus4F=0, fetch_valid=0.
//   - Reset mid-transaction abandons everything; imem is reset by the same rst_n.
//
//   States
//   - S_IDLE: go to S_REQ next cycle.
//   - S_REQ: imem_req=1, imem_addr=pc_q.
//     - imem_ready=1 -> S_WAIT, latching req_pc=pc_q.
//     - imem_addr may change while imem_ready=0 (redirect).
//   - S_WAIT: on imem_rsp_valid:
//     - Response is killed -> discard it, go to S_REQ.
//     - Otherwise register outputs: instr=rsp_data, PCf=req_pc, PCPlus4F=req_pc+4, fetch_valid=1.
//     - Then pc_q+=4; go to S_HOLD if StallF, else S_REQ.
//   - S_HOLD: outputs frozen while StallF=1; StallF=0 -> S_REQ.
//
//   Output timing
//   - A valid output lasts exactly one cycle with StallF=0; the next cycle it reverts to a bubble.
//   - Bubble: instr=NOP, fetch_valid=0, PCf/PCPlus4F unchanged.
//   - Latency: request acceptance to valid output is at least 2 cycles (rsp next cycle, registered output).
//   - Responses seen in S_IDLE or S_REQ are ignored.
//
//   Redirect (PCSrcE=1): highest priority, beats StallF and a same-cycle response.
//   - pc_q <= {PCTargetE[31:2],2'b00}.
//   - Outputs become a bubble next cycle.
//   - HOLD is cleared and state goes to S_REQ.
//   - In S_WAIT with no response this cycle: set kill; the next response is discarded, then kill=0.
//   - In S_WAIT with a response this cycle: discard it, kill stays 0.
//
//   Arithmetic and edge cases
//   - PC arithmetic is mod 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 = 0.
//   - StallF in S_REQ/S_WAIT does not block imem; a response is parked in S_HOLD.
//
// STRUCTURE
//   - fetch_pkg: NOP_INSTR, fetch_state_e {S_IDLE,S_REQ,S_WAIT,S_HOLD}, RESET_PC default.
//   - Sub-module fetch_out_reg: output register with load/bubble/hold controls.
//   - FSM, pc_q, req_pc and kill stay in fetch_unit.
//
// TESTING
//   - Reset, then imem 1-cycle latency and ready=1:
//     - imem_addr sequence 0,4,8.
//     - instr matches memory; PCPlus4F=PCf+4.
//     - fetch_valid pulses; NOP between fetches.
//   - StallF=1 for 3 cycles while a valid output is present:
//     - instr/PCf frozen, no new imem_req acceptance.
//     - Release resumes at PCf+4.
//   - PCSrcE=1, PCTargetE=32'h100 while in S_WAIT with rsp 2 cycles later:
//     - Late response is discarded (fetch_valid=0).
//     - Next imem_addr=32'h100.
//   - PCSrcE and imem_rsp_valid in the same cycle with StallF=1:
//     - Response dropped, bubble output, next imem_addr=target.
//   - RESET_PC=32'hFFFF_FFFC: second imem_addr=0.
//   - rst_n=0 asserted in S_WAIT: outputs return to reset values next edge; first fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// F-stage output register: loads a fetched instruction, inserts a NOP bubble,
// or holds its contents when neither control is asserted.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] load_instr,
  input  logic [W-1:0] load_pc,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus4,
  output logic         valid
);

  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pc_plus4_q, pc_plus4_d;
  logic         valid_q, valid_d;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (load) begin
      instr_d    = load_instr;
      pc_d       = load_pc;
      pc_plus4_d = load_pc + W'(4);
      valid_d    = 1'b1;
    end else if (bubble) begin
      // A bubble keeps the last PC pair so F/D sees stable addresses.
      instr_d = W'(NOP_INSTR);
      valid_d = 1'b0;
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q    <= W'(NOP_INSTR);
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC generation, single-outstanding imem requests, stall/redirect
// handling and bubble insertion in front of the F/D register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] PCf,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  fetch_valid
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  kill_q, kill_d;
  logic                  out_load, out_bubble;
  logic                  accept;
  logic                  unused_tgt_bits;

  // Target is forced word aligned; the low bits are deliberately dropped.
  assign unused_tgt_bits = ^PCTargetE[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    out_load   = 1'b0;
    out_bubble = 1'b0;
    // A killed request still owns the bus until its response drains.
    imem_req   = (state_q == S_REQ) && !kill_q;
    imem_addr  = pc_q;
    accept     = imem_req && imem_ready;

    if (kill_q && imem_rsp_valid) kill_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        out_bubble = 1'b1;
        state_d    = S_REQ;
      end
      S_REQ: begin
        out_bubble = 1'b1;
        if (accept) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        out_bubble = 1'b1;
        if (imem_rsp_valid) begin
          if (kill_q) begin
            state_d = S_REQ;
          end else begin
            out_load   = 1'b1;
            out_bubble = 1'b0;
            pc_d       = pc_q + DATA_WIDTH'(4);
            state_d    = StallF ? S_HOLD : S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!StallF) begin
          out_bubble = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides stall, hold and any same-cycle response.
    if (PCSrcE) begin
      pc_d       = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
      state_d    = S_REQ;
      out_load   = 1'b0;
      out_bubble = 1'b1;
      kill_d     = !imem_rsp_valid && (kill_q || (state_q == S_WAIT) || accept);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
    end
  end

  fetch_out_reg #(.W(DATA_WIDTH)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (out_load),
    .bubble    (out_bubble),
    .load_instr(imem_rsp_data),
    .load_pc   (req_pc_q),
    .instr     (instr),
    .pc        (PCf),
    .pc_plus4  (PCPlus4F),
    .valid     (fetch_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model plus directed
// scenarios (sequential fetch, stall, redirect, reset mid-fetch, PC wrap).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_f, pc_src_e, imem_ready;
  logic [31:0] pc_target_e;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, instr, pcf, pcp4;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pcf, w_pcp4;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data  = '0;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(stall_f), .PCSrcE(pc_src_e),
    .PCTargetE(pc_target_e), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr(instr), .PCf(pcf),
    .PCPlus4F(pcp4), .fetch_valid(fetch_valid)
  );

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .StallF(1'b0), .PCSrcE(1'b0),
    .PCTargetE(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .instr(w_instr), .PCf(w_pcf),
    .PCPlus4F(w_pcp4), .fetch_valid(w_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Instruction memory for the main DUT: response 'lat' cycles after acceptance.
  int lat = 1;
  always begin : imem_model
    logic        s_rst, s_acc, pend;
    logic [31:0] s_addr, pend_addr;
    int          cnt;
    @(negedge clk);
    s_rst  = rst_n;
    s_acc  = imem_req && imem_ready;
    s_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (s_rst !== 1'b1) begin
      pend = 1'b0;
    end else begin
      if (pend === 1'b1) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend           = 1'b0;
        end
      end
      if (s_acc) begin
        if (lat <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(s_addr);
        end else begin
          pend      = 1'b1;
          pend_addr = s_addr;
          cnt       = lat - 1;
        end
      end
    end
  end

  // Memory and recorder for the wrap-around instance.
  logic [31:0] w_addrs[$], w_pcfs[$], w_pcp4s[$], w_instrs[$];
  always begin : wrap_model
    logic        s_rst, s_acc;
    logic [31:0] s_addr;
    @(negedge clk);
    s_rst  = rst_n;
    s_acc  = w_req;
    s_addr = w_addr;
    if (s_rst === 1'b1 && s_acc) w_addrs.push_back(s_addr);
    if (s_rst === 1'b1 && w_valid) begin
      w_pcfs.push_back(w_pcf);
      w_pcp4s.push_back(w_pcp4);
      w_instrs.push_back(w_instr);
    end
    @(posedge clk);
    #1;
    w_rsp_valid = (s_rst === 1'b1) && s_acc;
    w_rsp_data  = mem_word(s_addr);
  end

  // Reference model: tracks outstanding requests and what F/D must see.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  initial begin : compare
    req_t        q[$];
    req_t        head;
    bit          have_snap, parked, have_rsp, accept;
    logic [31:0] m_pc, e_instr, e_pcf, e_pcp4;
    logic        e_valid;
    logic        s_rst, s_stall, s_src, s_req, s_ready, s_rsp;
    logic [31:0] s_tgt, s_addr;
    have_snap = 0;
    parked    = 0;
    m_pc      = '0;
    forever begin
      @(negedge clk);
      if (have_snap) begin
        if (s_rst !== 1'b1) begin
          q.delete();
          parked  = 0;
          m_pc    = '0;
          e_instr = NOP;
          e_pcf   = '0;
          e_pcp4  = '0;
          e_valid = 1'b0;
        end else begin
          have_rsp = 0;
          head     = '{addr: '0, stale: 1'b0};
          if (s_rsp && q.size() > 0) begin
            head     = q.pop_front();
            have_rsp = 1;
          end
          if (s_req) begin
            check("m_imem_addr", s_addr, m_pc);
            check("m_req_busy", {31'b0, (q.size() != 0) || parked}, 32'd0);
          end
          accept = s_req && s_ready;
          if (s_src) begin
            e_instr = NOP;
            e_valid = 1'b0;
            parked  = 0;
            m_pc    = {s_tgt[31:2], 2'b00};
            foreach (q[i]) q[i].stale = 1'b1;
            if (accept) q.push_back('{addr: s_addr, stale: 1'b1});
          end else begin
            if (have_rsp && !head.stale) begin
              e_instr = mem_word(head.addr);
              e_pcf   = head.addr;
              e_pcp4  = head.addr + 32'd4;
              e_valid = 1'b1;
              m_pc    = head.addr + 32'd4;
              parked  = s_stall;
            end else if (!(parked && s_stall)) begin
              e_instr = NOP;
              e_valid = 1'b0;
              parked  = 0;
            end
            if (accept) q.push_back('{addr: s_addr, stale: 1'b0});
          end
        end
        check("m_valid", {31'b0, fetch_valid}, {31'b0, e_valid});
        check("m_instr", instr, e_instr);
        check("m_pcf", pcf, e_pcf);
        check("m_pcp4", pcp4, e_pcp4);
      end
      s_rst   = rst_n;
      s_stall = stall_f;
      s_src   = pc_src_e;
      s_tgt   = pc_target_e;
      s_req   = imem_req;
      s_ready = imem_ready;
      s_addr  = imem_addr;
      s_rsp   = imem_rsp_valid;
      have_snap = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns in the cycle after the request was accepted (the S_WAIT cycle).
  task automatic wait_accept(input string name, input bit expect_bubble,
                             output logic [31:0] addr);
    bit got = 0;
    addr = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (imem_req && imem_ready) begin
        got  = 1;
        addr = imem_addr;
      end else if (expect_bubble) begin
        check({name, "_bubble"}, {31'b0, fetch_valid}, 32'd0);
      end
      tick();
    end
    check({name, "_accept"}, {31'b0, got}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = fetch_valid;
    end
    check({name, "_valid"}, {31'b0, got}, 32'd1);
  endtask

  initial begin : driver
    logic [31:0] a;
    rst_n       = 1'b0;
    stall_f     = 1'b0;
    pc_src_e    = 1'b0;
    pc_target_e = '0;
    imem_ready  = 1'b1;
    repeat (3) tick();
    check("rst_instr", instr, NOP);
    check("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_pcf", pcf, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch, 1-cycle memory.
    for (int i = 0; i < 3; i++) begin
      wait_accept("t1", 0, a);
      if (i > 0) begin
        check("t1_gap_valid", {31'b0, fetch_valid}, 32'd0);
        check("t1_gap_nop", instr, NOP);
        check("t1_gap_pcf", pcf, 32'(i * 4 - 4));
      end
      check("t1_addr", a, 32'(i * 4));
      wait_valid("t1");
      check("t1_instr", instr, 32'hC0DE_0000 + 32'(i * 4));
      check("t1_pcp4", pcp4, 32'(i * 4 + 4));
    end

    // Stall with a valid output present.
    wait_accept("t2", 0, a);
    check("t2_addr", a, 32'h0000_000C);
    stall_f = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_valid", {31'b0, fetch_valid}, 32'd1);
      check("t2_hold_pcf", pcf, 32'h0000_000C);
      check("t2_hold_instr", instr, 32'hC0DE_000C);
      check("t2_hold_noreq", {31'b0, imem_req}, 32'd0);
      tick();
    end
    stall_f = 1'b0;
    tick();
    wait_accept("t2r", 1, a);
    check("t2_resume_addr", a, 32'h0000_0010);
    wait_valid("t2r");
    check("t2_resume_instr", instr, 32'hC0DE_0010);

    // Redirect while waiting; stale response lands two cycles later.
    lat = 3;
    wait_accept("t3", 0, a);
    check("t3_addr", a, 32'h0000_0014);
    pc_src_e    = 1'b1;
    pc_target_e = 32'h0000_0100;
    tick();
    pc_src_e = 1'b0;
    lat      = 1;
    wait_accept("t3r", 1, a);
    check("t3_target_addr", a, 32'h0000_0100);
    wait_valid("t3r");
    check("t3_instr", instr, 32'hC0DE_0100);
    check("t3_pcf", pcf, 32'h0000_0100);

    // Redirect, response and stall in the same cycle; unaligned target.
    wait_accept("t4", 0, a);
    check("t4_addr", a, 32'h0000_0104);
    pc_src_e    = 1'b1;
    stall_f     = 1'b1;
    pc_target_e = 32'h0000_0202;
    tick();
    pc_src_e = 1'b0;
    stall_f  = 1'b0;
    check("t4_drop_valid", {31'b0, fetch_valid}, 32'd0);
    check("t4_drop_nop", instr, NOP);
    check("t4_drop_pcf", pcf, 32'h0000_0100);
    wait_accept("t4r", 1, a);
    check("t4_target_addr", a, 32'h0000_0200);
    wait_valid("t4r");
    check("t4_instr", instr, 32'hC0DE_0200);

    // Reset while a request is outstanding.
    wait_accept("t5", 0, a);
    check("t5_addr", a, 32'h0000_0204);
    rst_n = 1'b0;
    tick();
    check("t5_rst_instr", instr, NOP);
    check("t5_rst_pcf", pcf, 32'h0);
    check("t5_rst_pcp4", pcp4, 32'h0);
    check("t5_rst_valid", {31'b0, fetch_valid}, 32'd0);
    rst_n = 1'b1;
    wait_accept("t5r", 1, a);
    check("t5_first_addr", a, 32'h0);
    wait_valid("t5r");
    check("t5_instr", instr, 32'hC0DE_0000);

    // PC wrap from RESET_PC = FFFF_FFFC.
    check("wrap_count", {31'b0, w_addrs.size() >= 2 && w_pcfs.size() >= 1}, 32'd1);
    if (w_addrs.size() >= 2 && w_pcfs.size() >= 1) begin
      check("wrap_addr0", w_addrs[0], 32'hFFFF_FFFC);
      check("wrap_addr1", w_addrs[1], 32'h0000_0000);
      check("wrap_pcf0", w_pcfs[0], 32'hFFFF_FFFC);
      check("wrap_pcp4_0", w_pcp4s[0], 32'h0000_0000);
      check("wrap_instr0", w_instrs[0], 32'hC0DE_FFFC);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
